// File: rtl/tile_cfg_pkg.sv
// Shared definitions for the tile configuration loader.
//   state_t     : loader FSM states
//   idx_width   : element-index width, max(1, clog2(nb_e))
//   sub_width   : element-local address width, addr_w - idx_width
//   cnt_max     : saturation value of a cnt_w-bit counter
//   even_parity : XOR reduction used for the optional data parity check
package tile_cfg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic int idx_width(input int nb_e);
        int w;
        if (nb_e <= 2) begin
            w = 1;
        end else begin
            w = $clog2(nb_e);
        end
        return w;
    endfunction

    function automatic int sub_width(input int addr_w, input int nb_e);
        return addr_w - idx_width(nb_e);
    endfunction

    function automatic logic [63:0] cnt_max(input int cnt_w);
        logic [63:0] m;
        if (cnt_w >= 64) begin
            m = {64{1'b1}};
        end else begin
            m = (64'd1 << cnt_w) - 64'd1;
        end
        return m;
    endfunction

    function automatic logic even_parity(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/tile_cfg_loader_if.sv
// Tile configuration write bus (valid/ready).
//   select   : tile select from the column/row decoder
//   wr_valid : write request valid
//   wr_ready : loader can accept a write
//   address  : tile address (element index in the upper bits)
//   data     : configuration data
//   data_par : even parity over data, only when CFG_PARITY_EN is defined
// Modports: master drives the request, slave (the loader) drives wr_ready.
interface tile_cfg_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              select;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
`ifdef CFG_PARITY_EN
    logic              data_par;

    modport master (output select, wr_valid, address, data, data_par, input wr_ready);
    modport slave  (input select, wr_valid, address, data, data_par, output wr_ready);
`else
    modport master (output select, wr_valid, address, data, input wr_ready);
    modport slave  (input select, wr_valid, address, data, output wr_ready);
`endif
endinterface

// File: rtl/tile_cfg_decoder.sv
// Combinational element-index decoder.
//   idx          : element index taken from the tile address
//   onehot       : one-hot element select (all zero when out of range)
//   out_of_range : idx does not name an existing element
module tile_cfg_decoder #(
    parameter int NB_E  = 2,
    parameter int IDX_W = 1
) (
    input  logic [IDX_W-1:0] idx,
    output logic [NB_E-1:0]  onehot,
    output logic             out_of_range
);

    // Decode the index into one select line per element.
    always_comb begin
        onehot       = '0;
        out_of_range = (32'(idx) >= 32'(NB_E));
        for (int i = 0; i < NB_E; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/tile_cfg_loader.sv
// Tile configuration loader: accepts a write from the tile bus, then holds a
// registered one-hot element select with local address and data for HOLD cycles.
//   clk, rst_n     : configuration clock, asynchronous active-low reset
//   bus            : tile write bus (slave side)
//   clear          : synchronous clear of wr_count and sticky errors
//   select_elem    : one-hot element select
//   address_elem   : element-local address (retained in idle)
//   data_elem      : element data (retained in idle)
//   wr_count       : accepted clean writes, saturating
//   err_range      : sticky, index beyond the last element was received
//   err_parity     : sticky parity error (constant 0 without CFG_PARITY_EN)
// Optional feature macro: CFG_PARITY_EN (adds bus.data_par check).
module tile_cfg_loader
    import tile_cfg_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int NB_E     = 2,
    parameter int HOLD     = 1,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = idx_width(NB_E),
    localparam int SUB_W   = sub_width(ADDR_W, NB_E)
) (
    input  logic              clk,
    input  logic              rst_n,
    tile_cfg_loader_if.slave  bus,
    input  logic              clear,
    output logic [NB_E-1:0]   select_elem,
    output logic [SUB_W-1:0]  address_elem,
    output logic [DATA_W-1:0] data_elem,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_range,
    output logic              err_parity
);

    localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_max(CNT_W));

    state_t            state_r, state_n;
    logic [HOLD_W-1:0] hold_r, hold_n;
    logic [NB_E-1:0]   sel_r, sel_n;
    logic [SUB_W-1:0]  addr_r, addr_n;
    logic [DATA_W-1:0] data_r, data_n;
    logic              ready_r, ready_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n, cnt_base_s;
    logic              err_range_r, err_range_n;
    logic [NB_E-1:0]   onehot_s;
    logic              out_of_range_s;
    logic              par_ok_s;
    logic              accept_s;
    logic              write_ok_s;

    tile_cfg_decoder #(
        .NB_E  (NB_E),
        .IDX_W (IDX_W)
    ) u_decoder (
        .idx          (bus.address[ADDR_W-1:SUB_W]),
        .onehot       (onehot_s),
        .out_of_range (out_of_range_s)
    );

`ifdef CFG_PARITY_EN
    logic err_par_r, err_par_n;

    // Data carries even parity: the parity bit must equal the XOR of the data.
    always_comb begin
        par_ok_s = (even_parity(64'(bus.data)) == bus.data_par);
    end

    // Sticky parity flag; clear applies first so a same-cycle bad write still sets it.
    always_comb begin
        err_par_n = (clear ? 1'b0 : err_par_r) | (accept_s & ~par_ok_s);
    end

    // Parity flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_par_r <= 1'b0;
        end else begin
            err_par_r <= err_par_n;
        end
    end

    assign err_parity = err_par_r;
`else
    assign par_ok_s   = 1'b1;
    assign err_parity = 1'b0;
`endif

    // ready_r is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept_s   = bus.select & bus.wr_valid & ready_r & (state_r == ST_IDLE);
    // A write reaches an element only if it names one and its data is clean.
    assign write_ok_s = ~out_of_range_s & par_ok_s;

    // FSM next state and registered element-side outputs.
    always_comb begin
        state_n = state_r;
        hold_n  = hold_r;
        sel_n   = sel_r;
        addr_n  = addr_r;
        data_n  = data_r;
        ready_n = ready_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = ST_ISSUE;
                    hold_n  = HOLD_LOAD;
                    sel_n   = write_ok_s ? onehot_s : '0;
                    addr_n  = bus.address[SUB_W-1:0];
                    data_n  = bus.data;
                    ready_n = 1'b0;
                end else begin
                    // Also raises ready on the first edge after reset release.
                    ready_n = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (hold_r == '0) begin
                    state_n = ST_IDLE;
                    sel_n   = '0;
                    ready_n = 1'b1;
                end else begin
                    hold_n = hold_r - HOLD_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                sel_n   = '0;
                ready_n = 1'b0;
            end
        endcase
    end

    // Counter and range flag: clear first, then the accept of the same cycle.
    always_comb begin
        cnt_base_s  = clear ? '0 : cnt_r;
        err_range_n = (clear ? 1'b0 : err_range_r) | (accept_s & out_of_range_s);
        if (accept_s && write_ok_s && (cnt_base_s != CNT_MAX)) begin
            cnt_n = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_n = cnt_base_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_r      <= '0;
            sel_r       <= '0;
            addr_r      <= '0;
            data_r      <= '0;
            ready_r     <= 1'b0;
            cnt_r       <= '0;
            err_range_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            hold_r      <= hold_n;
            sel_r       <= sel_n;
            addr_r      <= addr_n;
            data_r      <= data_n;
            ready_r     <= ready_n;
            cnt_r       <= cnt_n;
            err_range_r <= err_range_n;
        end
    end

    assign bus.wr_ready  = ready_r;
    assign select_elem   = sel_r;
    assign address_elem  = addr_r;
    assign data_elem     = data_r;
    assign wr_count      = cnt_r;
    assign err_range     = err_range_r;

endmodule

// File: doc/tile_cfg_loader.md
# tile_cfg_loader

Parametrised configuration loader for fabric tiles. Accepts tile-level configuration writes on a valid/ready handshake, splits the tile address into an element index and an element-local address, and drives a registered one-hot select, address and data to one of NB_E configurable elements (switch boxes, clusters) for HOLD cycles. Instantiated once per tile between the tile configuration bus and its elements, replacing the fixed-width single-element loader.

## Interface
- ADDR_W, 10, tile address width
- DATA_W, 8, configuration data width
- NB_E, 2, number of configurable elements in the tile (≥1)
- HOLD, 1, cycles each element select is held asserted (≥1)
- CNT_W, 16, accepted-write counter width
- Derived: IDX_W = max(1, clog2(NB_E)); SUB_W = ADDR_W − IDX_W
- CLK  in  1  configuration clock (tile `conf` net)
- RESET  in  1  asynchronous, active-low reset
- SELECT  in  1  tile select from column/row decoder
- WR_VALID  in  1  write request valid
- WR_READY  out  1  loader can accept a write
- ADDRESS  in  ADDR_W  tile address; [ADDR_W−1:SUB_W] element index, [SUB_W−1:0] local address
- DATA  in  DATA_W  configuration data
- CLEAR  in  1  synchronous clear of counter and sticky errors
- SELECT_ELEM  out  NB_E  one-hot element select
- ADDRESS_ELEM  out  SUB_W  element-local address
- DATA_ELEM  out  DATA_W  element data
- WR_COUNT  out  CNT_W  accepted in-range writes, saturating
- ERR_RANGE  out  1  sticky: element index ≥ NB_E received
- ERR_PARITY  out  1  sticky parity error (0 when CFG_PARITY_EN undefined)
- DATA_PAR  in  1  even parity over DATA (present only with CFG_PARITY_EN)

## Operation
- FSM states: IDLE, ISSUE. WR_READY = 1 only in IDLE after reset release.
- Accept = SELECT & WR_VALID & WR_READY in IDLE. On accept: register index, local address, data; go to ISSUE; load hold counter with HOLD−1.
- ISSUE: SELECT_ELEM[idx] = 1 (others 0), ADDRESS_ELEM/DATA_ELEM stable; counter decrements; at 0 return to IDLE.
- Index ≥ NB_E: write accepted, FSM still spends HOLD cycles in ISSUE with SELECT_ELEM = 0, ERR_RANGE set, WR_COUNT unchanged.
- WR_COUNT increments on each accepted in-range (and parity-clean) write; holds at 2^CNT_W − 1.
- CLEAR: zeroes WR_COUNT and error flags; an accept in the same cycle is applied after the clear (count becomes 1, or flag set).
- WR_VALID without SELECT is ignored; SELECT/WR_VALID deasserted during ISSUE has no effect.
- ADDRESS_ELEM/DATA_ELEM retain last value in IDLE; SELECT_ELEM = 0 in IDLE.

## Timing
- Reset (RESET low, async): state IDLE, WR_READY 0, SELECT_ELEM 0, ADDRESS_ELEM 0, DATA_ELEM 0, WR_COUNT 0, ERR_RANGE 0, ERR_PARITY 0. WR_READY rises on first CLK edge after RESET high.
- Accept at edge N → SELECT_ELEM valid from N+1 through N+HOLD; WR_READY 0 in that window, 1 from N+HOLD+1. Throughput: one write per HOLD+1 cycles.
- WR_COUNT/errors update at edge N (visible cycle N+1).
- RESET asserted mid-ISSUE: select drops immediately, write lost, not counted.

## Configuration
- CFG_PARITY_EN defined: DATA_PAR port exists; on accept, if ^DATA ≠ DATA_PAR the write is accepted, no element selected (HOLD cycles still spent), ERR_PARITY set, not counted.
- CFG_PARITY_EN undefined: no DATA_PAR port, no check, ERR_PARITY tied 0.

## Structure
- Package tile_cfg_pkg: FSM state enum, IDX_W/SUB_W derivation function, counter-saturation constant helper.
- Sub-module tile_cfg_decoder: combinational index → one-hot NB_E decode with out-of-range flag.

## Test plan
- Reset, NB_E=2, HOLD=1: write addr 0x205 data 0xA5 → cycle after accept SELECT_ELEM=2'b10, ADDRESS_ELEM=0x005, DATA_ELEM=0xA5 for 1 cycle; WR_COUNT=1.
- HOLD=3, back-to-back WR_VALID held high: accepts spaced 4 cycles; each select 3 cycles wide.
- NB_E=3 (IDX_W=2, SUB_W=8), index 3 → SELECT_ELEM=0, ERR_RANGE=1, WR_COUNT unchanged; CLEAR → ERR_RANGE=0.
- CNT_W=2, five valid writes → WR_COUNT stops at 3; CLEAR with simultaneous accept → WR_COUNT=1.
- RESET low during ISSUE → all outputs 0 at once; WR_READY 1 one edge after release.
- CFG_PARITY_EN: DATA=0x01, DATA_PAR=0 → no select, ERR_PARITY=1; DATA_PAR=1 → normal write.
